// File: rtl/motion_zone_detector_if.sv
// Pixel-pair stream, frame markers, thresholds and zone report of motion_zone_detector.
// The per-pixel mask outputs exist only when MOTION_PIXEL_MASK_EN is defined.
interface motion_zone_detector_if #(
  parameter int PIX_WIDTH = 10,
  parameter int NUM_ZONES = 4,
  parameter int CNT_WIDTH = 20
);
  logic                           iFRAME_START;
  logic                           iFRAME_END;
  logic                           iDVAL;
  logic [PIX_WIDTH-1:0]           iCURR;
  logic [PIX_WIDTH-1:0]           iPREV;
  logic [PIX_WIDTH-1:0]           iTHRESHOLD;
  logic [CNT_WIDTH-1:0]           iMIN_COUNT;
  logic [NUM_ZONES*CNT_WIDTH-1:0] oZONE_COUNT;
  logic [NUM_ZONES-1:0]           oZONE_MOTION;
  logic                           oMOTION_ANY;
  logic                           oREPORT_VALID;
  logic                           oBUSY;
`ifdef MOTION_PIXEL_MASK_EN
  logic                           oPIX_MOTION;
  logic                           oPIX_VALID;
`endif

  modport master (
    output iFRAME_START, iFRAME_END, iDVAL, iCURR, iPREV, iTHRESHOLD, iMIN_COUNT,
`ifdef MOTION_PIXEL_MASK_EN
    input  oPIX_MOTION, oPIX_VALID,
`endif
    input  oZONE_COUNT, oZONE_MOTION, oMOTION_ANY, oREPORT_VALID, oBUSY
  );

  modport slave (
    input  iFRAME_START, iFRAME_END, iDVAL, iCURR, iPREV, iTHRESHOLD, iMIN_COUNT,
`ifdef MOTION_PIXEL_MASK_EN
    output oPIX_MOTION, oPIX_VALID,
`endif
    output oZONE_COUNT, oZONE_MOTION, oMOTION_ANY, oREPORT_VALID, oBUSY
  );
endinterface

// File: rtl/motion_zone_detector.sv
// Counts motion pixels (|curr - prev| > threshold) per vertical column band over
// a frame and reports persistence-filtered per-zone motion flags at frame end.
// Optional per-pixel mask outputs (oPIX_MOTION/oPIX_VALID): define MOTION_PIXEL_MASK_EN.
//
// state  | meaning
// IDLE   | waiting for iFRAME_START; pixels and iFRAME_END ignored
// ACTIVE | pixel pairs accepted into the diff/compare pipeline
// DRAIN  | two cycles so the last pixel reaches the zone counters
// REPORT | persistence update; outputs registered on leaving this state
module motion_zone_detector #(
  parameter int PIX_WIDTH = 10,
  parameter int IMG_WIDTH = 640,
  parameter int NUM_ZONES = 4,
  parameter int CNT_WIDTH = 20,
  parameter int PERSIST   = 2
) (
  input logic                   iCLK,
  input logic                   iRST_N,
  motion_zone_detector_if.slave bus
);
  localparam int ZONE_W = IMG_WIDTH / NUM_ZONES;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ZPIX_W = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
  localparam int ZIDX_W = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ZPIX_W-1:0]    ZPIX_LAST = ZPIX_W'(ZONE_W - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [3:0]           PERSIST_V = 4'(PERSIST);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_REPORT} state_t;

  state_t                         state_q, state_d;
  logic                           drain_q;
  logic [PIX_WIDTH-1:0]           thr_q;
  logic [CNT_WIDTH-1:0]           min_q;
  logic [COL_W-1:0]               col_q;
  logic [ZPIX_W-1:0]              zpix_q;
  logic [ZIDX_W-1:0]              zone_q;
  logic                           s1_vld_q;
  logic [PIX_WIDTH-1:0]           s1_diff_q;
  logic [ZIDX_W-1:0]              s1_zone_q;
  logic [CNT_WIDTH-1:0]           cnt_q     [NUM_ZONES];
  logic [3:0]                     persist_q [NUM_ZONES];
  logic [3:0]                     persist_d [NUM_ZONES];
  logic [NUM_ZONES-1:0]           motion_d, motion_q;
  logic [NUM_ZONES*CNT_WIDTH-1:0] count_flat, count_q;
  logic                           any_q, valid_q, busy;
  logic [PIX_WIDTH-1:0]           diff;
  logic                           take_start, pix_ok, hit;

  // An abort (start while ACTIVE) behaves like a fresh start; DRAIN/REPORT ignore it.
  assign take_start = bus.iFRAME_START && (state_q == S_IDLE || state_q == S_ACTIVE);
  assign pix_ok     = bus.iDVAL && (state_q == S_ACTIVE) && !bus.iFRAME_START;
  assign diff       = (bus.iCURR >= bus.iPREV) ? (bus.iCURR - bus.iPREV) : (bus.iPREV - bus.iCURR);
  assign hit        = s1_vld_q && (s1_diff_q > thr_q);

  // state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic; abort has priority over frame end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.iFRAME_START) state_d = S_ACTIVE;
      S_ACTIVE: if (!bus.iFRAME_START && bus.iFRAME_END) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == 1'b0) state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // output/report logic: persistence update from the final counts, busy flag
  always_comb begin
    busy       = (state_q != S_IDLE);
    count_flat = '0;
    motion_d   = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      count_flat[z*CNT_WIDTH +: CNT_WIDTH] = cnt_q[z];
      persist_d[z] = 4'd0;
      if (cnt_q[z] >= min_q)
        persist_d[z] = (persist_q[z] == PERSIST_V) ? persist_q[z] : persist_q[z] + 4'd1;
      motion_d[z] = (persist_d[z] == PERSIST_V);
    end
  end

  // datapath: drain timer, column/zone tracking, two-stage pixel pipeline, zone counters, report registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      drain_q   <= 1'b0;
      thr_q     <= '0;
      min_q     <= '0;
      col_q     <= '0;
      zpix_q    <= '0;
      zone_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s1_zone_q <= '0;
      count_q   <= '0;
      motion_q  <= '0;
      any_q     <= 1'b0;
      valid_q   <= 1'b0;
      for (int z = 0; z < NUM_ZONES; z++) begin
        cnt_q[z]     <= '0;
        persist_q[z] <= '0;
      end
    end else begin
      valid_q  <= 1'b0;
      s1_vld_q <= pix_ok;
      if (pix_ok) begin
        s1_diff_q <= diff;
        s1_zone_q <= zone_q;
      end
      if (state_q == S_ACTIVE)                       drain_q <= 1'b1;
      else if (state_q == S_DRAIN && drain_q != 1'b0) drain_q <= drain_q - 1'b1;
      if (take_start) begin
        thr_q  <= bus.iTHRESHOLD;
        min_q  <= bus.iMIN_COUNT;
        col_q  <= '0;
        zone_q <= '0;
        zpix_q <= ZPIX_LAST;
        for (int z = 0; z < NUM_ZONES; z++) cnt_q[z] <= '0;
      end else begin
        for (int z = 0; z < NUM_ZONES; z++)
          if (hit && s1_zone_q == ZIDX_W'(z) && cnt_q[z] != CNT_MAX)
            cnt_q[z] <= cnt_q[z] + CNT_WIDTH'(1);
        if (pix_ok) begin
          if (col_q == COL_LAST) begin
            col_q  <= '0;
            zone_q <= '0;
            zpix_q <= ZPIX_LAST;
          end else begin
            col_q <= col_q + COL_W'(1);
            if (zpix_q == '0) begin
              zpix_q <= ZPIX_LAST;
              zone_q <= zone_q + ZIDX_W'(1);
            end else begin
              zpix_q <= zpix_q - ZPIX_W'(1);
            end
          end
        end
      end
      if (state_q == S_REPORT) begin
        for (int z = 0; z < NUM_ZONES; z++) persist_q[z] <= persist_d[z];
        motion_q <= motion_d;
        any_q    <= |motion_d;
        count_q  <= count_flat;
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.oZONE_COUNT   = count_q;
  assign bus.oZONE_MOTION  = motion_q;
  assign bus.oMOTION_ANY   = any_q;
  assign bus.oREPORT_VALID = valid_q;
  assign bus.oBUSY         = busy;

`ifdef MOTION_PIXEL_MASK_EN
  logic pix_motion_q, pix_valid_q;

  // per-pixel overlay mask, aligned with the stage-2 compare
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pix_motion_q <= 1'b0;
      pix_valid_q  <= 1'b0;
    end else begin
      pix_motion_q <= hit;
      pix_valid_q  <= s1_vld_q;
    end
  end

  assign bus.oPIX_MOTION = pix_motion_q;
  assign bus.oPIX_VALID  = pix_valid_q;
`endif
endmodule

// File: tb/tb_motion_zone_detector.sv
module tb_motion_zone_detector;
  localparam int PW = 10, IW = 16, NZ = 4, CW = 20, CWS = 3, PER = 2, ZW = IW / NZ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          frame_start = 1'b0, frame_end = 1'b0, dval = 1'b0;
  logic [PW-1:0] curr = '0, prev = '0, thr_in = '0;
  logic [CW-1:0] min_in = '0;

  motion_zone_detector_if #(.PIX_WIDTH(PW), .NUM_ZONES(NZ), .CNT_WIDTH(CW))  bus_a ();
  motion_zone_detector_if #(.PIX_WIDTH(PW), .NUM_ZONES(NZ), .CNT_WIDTH(CWS)) bus_b ();

  assign bus_a.iFRAME_START = frame_start;
  assign bus_a.iFRAME_END   = frame_end;
  assign bus_a.iDVAL        = dval;
  assign bus_a.iCURR        = curr;
  assign bus_a.iPREV        = prev;
  assign bus_a.iTHRESHOLD   = thr_in;
  assign bus_a.iMIN_COUNT   = min_in;
  assign bus_b.iFRAME_START = frame_start;
  assign bus_b.iFRAME_END   = frame_end;
  assign bus_b.iDVAL        = dval;
  assign bus_b.iCURR        = curr;
  assign bus_b.iPREV        = prev;
  assign bus_b.iTHRESHOLD   = thr_in;
  assign bus_b.iMIN_COUNT   = 3'd7;

  motion_zone_detector #(.PIX_WIDTH(PW), .IMG_WIDTH(IW), .NUM_ZONES(NZ), .CNT_WIDTH(CW), .PERSIST(PER))
    dut_a (.iCLK(clk), .iRST_N(rst_n), .bus(bus_a));
  motion_zone_detector #(.PIX_WIDTH(PW), .IMG_WIDTH(IW), .NUM_ZONES(NZ), .CNT_WIDTH(CWS), .PERSIST(PER))
    dut_b (.iCLK(clk), .iRST_N(rst_n), .bus(bus_b));

  int checks = 0, passed = 0, rv_cnt = 0;
  int unsigned q_curr[$], q_prev[$], hot_c[$], hot_p[$];
  int pers_a[NZ], pers_b[NZ];
  logic [NZ*CW-1:0]  exp_cnt_a;
  logic [NZ*CWS-1:0] exp_cnt_b;
  logic [NZ-1:0]     exp_mot_a, exp_mot_b;
  int lat;
  bit busy_drain, pulse_long;

  always @(posedge clk) if (bus_a.oREPORT_VALID === 1'b1) rv_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: counts from the pixel list by column position, then persistence.
  task automatic model_report(input int thr, input int minc);
    int raw[NZ];
    int d, ca, cb;
    for (int z = 0; z < NZ; z++) raw[z] = 0;
    foreach (q_curr[i]) begin
      d = int'(q_curr[i]) - int'(q_prev[i]);
      if (d < 0) d = -d;
      if (d > thr) raw[(i % IW) / ZW]++;
    end
    for (int z = 0; z < NZ; z++) begin
      ca = raw[z];
      cb = (raw[z] > 7) ? 7 : raw[z];
      exp_cnt_a[z*CW +: CW]   = CW'(ca);
      exp_cnt_b[z*CWS +: CWS] = CWS'(cb);
      pers_a[z] = (ca >= minc) ? ((pers_a[z] < PER) ? pers_a[z] + 1 : PER) : 0;
      pers_b[z] = (cb >= 7) ? ((pers_b[z] < PER) ? pers_b[z] + 1 : PER) : 0;
      exp_mot_a[z] = (pers_a[z] == PER);
      exp_mot_b[z] = (pers_b[z] == PER);
    end
  endtask

  task automatic push_px(input int c, input int p);
    q_curr.push_back(c);
    q_prev.push_back(p);
  endtask

  task automatic clear_q();
    q_curr.delete();
    q_prev.delete();
  endtask

  // Drives one frame from the queues and waits for its report; thresholds are scrambled after start.
  task automatic send_frame(input int thr, input int minc, input bit end_last, input bit gaps);
    int n;
    n = q_curr.size();
    @(negedge clk);
    frame_start = 1'b1; thr_in = PW'(thr); min_in = CW'(minc);
    @(negedge clk);
    frame_start = 1'b0; thr_in = PW'($urandom_range(0, 1023)); min_in = CW'($urandom_range(0, 50));
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        dval = 1'b0; curr = PW'($urandom); prev = PW'($urandom);
        @(negedge clk);
      end
      dval = 1'b1; curr = PW'(q_curr[i]); prev = PW'(q_prev[i]);
      frame_end = end_last && (i == n - 1);
      @(negedge clk);
    end
    if (!end_last || n == 0) begin
      dval = 1'b0; frame_end = 1'b1;
      @(negedge clk);
    end
    frame_end = 1'b0;
    model_report(thr, minc);
    busy_drain = bus_a.oBUSY;
    lat = 1;
    while (bus_a.oREPORT_VALID !== 1'b1 && lat < 12) begin
      dval = 1'b1; curr = '0; prev = '1;
      @(negedge clk);
      lat++;
    end
    dval = 1'b0;
    @(negedge clk);
    pulse_long = bus_a.oREPORT_VALID;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int rv0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.oZONE_COUNT, bus_a.oZONE_MOTION, bus_a.oMOTION_ANY, bus_a.oREPORT_VALID, bus_a.oBUSY} !== '0)
      $display("FAIL reset_outputs: got count=%h motion=%b any=%b valid=%b busy=%b expected all 0",
               bus_a.oZONE_COUNT, bus_a.oZONE_MOTION, bus_a.oMOTION_ANY, bus_a.oREPORT_VALID, bus_a.oBUSY);
    else passed++;
    rst_n = 1'b1;
    rv0 = rv_cnt;
    dval = 1'b1; curr = '0; prev = '1; frame_end = 1'b1;
    repeat (3) @(negedge clk);
    dval = 1'b0; frame_end = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus_a.oBUSY !== 1'b0 || rv_cnt !== rv0)
      $display("FAIL idle_ignores: got busy=%b reports=%0d expected busy=0 reports=%0d", bus_a.oBUSY, rv_cnt, rv0);
    else passed++;
  endtask

  task automatic test_threshold();
    clear_q();
    for (int c = 0; c < IW; c++) begin
      int r;
      r = $urandom_range(0, 1023);
      case (c)
        4: push_px(400, 0);
        5: push_px(0, 401);
        6: push_px(0, 1023);
        7: push_px(401, 0);
        default: push_px(r, r);
      endcase
    end
    hot_c = q_curr; hot_p = q_prev;
    send_frame(400, 3, 1'b1, 1'b0);
    checks++;
    if (bus_a.oZONE_COUNT !== exp_cnt_a)
      $display("FAIL thr_counts: got %h expected %h", bus_a.oZONE_COUNT, exp_cnt_a);
    else passed++;
    checks++;
    if (bus_a.oZONE_MOTION !== exp_mot_a)
      $display("FAIL thr_motion: got %b expected %b", bus_a.oZONE_MOTION, exp_mot_a);
    else passed++;
    checks++;
    if (lat !== 4) $display("FAIL thr_latency: got %0d expected 4", lat);
    else passed++;
  endtask

  task automatic test_persistence();
    for (int f = 0; f < 3; f++) begin
      clear_q();
      if (f < 2) begin
        q_curr = hot_c; q_prev = hot_p;
      end else begin
        for (int c = 0; c < IW; c++) begin
          int r;
          r = $urandom_range(0, 1023);
          push_px(r, r);
        end
      end
      send_frame(400, 3, f[0], 1'b1);
      checks++;
      if (bus_a.oZONE_MOTION !== exp_mot_a || bus_a.oMOTION_ANY !== (|exp_mot_a))
        $display("FAIL persist_f%0d: got motion=%b any=%b expected motion=%b any=%b",
                 f, bus_a.oZONE_MOTION, bus_a.oMOTION_ANY, exp_mot_a, |exp_mot_a);
      else passed++;
      checks++;
      if (bus_a.oZONE_COUNT !== exp_cnt_a)
        $display("FAIL persist_count_f%0d: got %h expected %h", f, bus_a.oZONE_COUNT, exp_cnt_a);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    for (int f = 0; f < 2; f++) begin
      q_curr = hot_c; q_prev = hot_p;
      send_frame(400, 3, 1'b0, 1'b0);
    end
    @(negedge clk);
    frame_start = 1'b1; thr_in = PW'(400); min_in = CW'(3);
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dval = 1'b1; curr = '0; prev = '1;
      @(negedge clk);
    end
    dval = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.oZONE_COUNT, bus_a.oZONE_MOTION, bus_a.oMOTION_ANY, bus_a.oREPORT_VALID, bus_a.oBUSY} !== '0)
      $display("FAIL reset_mid_outputs: got count=%h motion=%b any=%b busy=%b expected all 0",
               bus_a.oZONE_COUNT, bus_a.oZONE_MOTION, bus_a.oMOTION_ANY, bus_a.oBUSY);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int z = 0; z < NZ; z++) begin
      pers_a[z] = 0;
      pers_b[z] = 0;
    end
    q_curr = hot_c; q_prev = hot_p;
    send_frame(400, 3, 1'b1, 1'b1);
    checks++;
    if (bus_a.oZONE_COUNT !== exp_cnt_a || bus_a.oZONE_MOTION !== exp_mot_a)
      $display("FAIL reset_mid_next: got count=%h motion=%b expected count=%h motion=%b",
               bus_a.oZONE_COUNT, bus_a.oZONE_MOTION, exp_cnt_a, exp_mot_a);
    else passed++;
  endtask

  task automatic test_wrap();
    clear_q();
    for (int i = 0; i < 2 * IW; i++) begin
      int p;
      p = $urandom_range(0, 600);
      if (i % IW == IW - 1) push_px(1023, $urandom_range(0, 200));
      else                  push_px(p + $urandom_range(0, 400), p);
    end
    send_frame(400, 3, 1'b1, 1'b1);
    checks++;
    if (bus_a.oZONE_COUNT !== exp_cnt_a)
      $display("FAIL wrap_counts: got %h expected %h", bus_a.oZONE_COUNT, exp_cnt_a);
    else passed++;
    checks++;
    if (lat !== 4 || pulse_long !== 1'b0 || busy_drain !== 1'b1)
      $display("FAIL wrap_timing: got lat=%0d pulse_after=%b busy=%b expected lat=4 pulse_after=0 busy=1",
               lat, pulse_long, busy_drain);
    else passed++;
  endtask

  task automatic test_abort();
    int rv0;
    rv0 = rv_cnt;
    @(negedge clk);
    frame_start = 1'b1; thr_in = PW'(400); min_in = CW'(3);
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dval = 1'b1; curr = '0; prev = '1;
      @(negedge clk);
    end
    dval = 1'b0;
    clear_q();
    for (int c = 0; c < IW; c++) begin
      int r;
      r = $urandom_range(0, 1023);
      push_px(r, r);
    end
    send_frame(100, 3, 1'b1, 1'b0);
    checks++;
    if (rv_cnt !== rv0 + 1)
      $display("FAIL abort_reports: got %0d reports expected %0d", rv_cnt - rv0, 1);
    else passed++;
    checks++;
    if (bus_a.oZONE_COUNT !== exp_cnt_a || bus_a.oZONE_MOTION !== exp_mot_a)
      $display("FAIL abort_counts: got count=%h motion=%b expected count=%h motion=%b",
               bus_a.oZONE_COUNT, bus_a.oZONE_MOTION, exp_cnt_a, exp_mot_a);
    else passed++;
  endtask

  task automatic test_saturation();
    int hot;
    hot = 0;
    clear_q();
    for (int i = 0; i < 3 * IW; i++) begin
      int r;
      r = $urandom_range(0, 500);
      if ((i % IW) / ZW == 2 && hot < 10) begin
        push_px(r + 450, r);
        hot++;
      end else push_px(r, r);
    end
    send_frame(400, 3, 1'b0, 1'b1);
    checks++;
    if (bus_b.oZONE_COUNT !== exp_cnt_b)
      $display("FAIL sat_counts_small: got %h expected %h", bus_b.oZONE_COUNT, exp_cnt_b);
    else passed++;
    checks++;
    if (bus_b.oZONE_MOTION !== exp_mot_b)
      $display("FAIL sat_motion_small: got %b expected %b", bus_b.oZONE_MOTION, exp_mot_b);
    else passed++;
    checks++;
    if (bus_a.oZONE_COUNT !== exp_cnt_a)
      $display("FAIL sat_counts_wide: got %h expected %h", bus_a.oZONE_COUNT, exp_cnt_a);
    else passed++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 14; f++) begin
      int n, thr, minc;
      n    = $urandom_range(0, 40);
      thr  = $urandom_range(0, 1023);
      minc = $urandom_range(0, 6);
      clear_q();
      for (int i = 0; i < n; i++) push_px($urandom_range(0, 1023), $urandom_range(0, 1023));
      send_frame(thr, minc, 1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (bus_a.oZONE_COUNT !== exp_cnt_a || bus_b.oZONE_COUNT !== exp_cnt_b)
        $display("FAIL rand_counts_f%0d: got a=%h b=%h expected a=%h b=%h",
                 f, bus_a.oZONE_COUNT, bus_b.oZONE_COUNT, exp_cnt_a, exp_cnt_b);
      else passed++;
      checks++;
      if (bus_a.oZONE_MOTION !== exp_mot_a || bus_a.oMOTION_ANY !== (|exp_mot_a) ||
          bus_b.oZONE_MOTION !== exp_mot_b)
        $display("FAIL rand_motion_f%0d: got a=%b any=%b b=%b expected a=%b any=%b b=%b",
                 f, bus_a.oZONE_MOTION, bus_a.oMOTION_ANY, bus_b.oZONE_MOTION,
                 exp_mot_a, |exp_mot_a, exp_mot_b);
      else passed++;
      checks++;
      if (lat !== 4 || pulse_long !== 1'b0 || busy_drain !== 1'b1)
        $display("FAIL rand_timing_f%0d: got lat=%0d pulse_after=%b busy=%b expected lat=4 pulse_after=0 busy=1",
                 f, lat, pulse_long, busy_drain);
      else passed++;
    end
  endtask

  initial begin
    for (int z = 0; z < NZ; z++) begin
      pers_a[z] = 0;
      pers_b[z] = 0;
    end
    test_reset();
    test_threshold();
    test_persistence();
    test_reset_mid();
    test_wrap();
    test_abort();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/motion_zone_detector.md
Name: motion_zone_detector

Overview:
- Streaming successor to the single-pixel RAW frame differencer.
- Takes paired current and previous RAW pixels from the frame-buffer readout and registers their absolute difference.
- Counts motion pixels per vertical screen zone (column bands) over a full frame.
- At end of frame, reports per-zone motion flags with multi-frame persistence filtering, for the paddle-control logic.

Parameters:
- PIX_WIDTH, 10: RAW pixel width.
- IMG_WIDTH, 640: active pixels per line; must be divisible by NUM_ZONES.
- NUM_ZONES, 4: number of equal-width column bands.
- CNT_WIDTH, 20: per-zone motion-pixel counter width.
- PERSIST, 2: consecutive hot frames required before a zone flag asserts (1..15).

Ports:
- iCLK, in, 1: pixel clock.
- iRST_N, in, 1: reset, asynchronous assert, active-low.
- iFRAME_START, in, 1: one-cycle pulse before the first pixel of a frame.
- iFRAME_END, in, 1: one-cycle pulse, on or after the last pixel.
- iDVAL, in, 1: pixel pair valid.
- iCURR, in, PIX_WIDTH: current-frame pixel.
- iPREV, in, PIX_WIDTH: previous-frame pixel at the same position.
- iTHRESHOLD, in, PIX_WIDTH: motion threshold.
- iMIN_COUNT, in, CNT_WIDTH: minimum motion pixels for a zone to be hot.
- oZONE_COUNT, out, NUM_ZONES*CNT_WIDTH: last reported counts; zone 0 in the LSBs.
- oZONE_MOTION, out, NUM_ZONES: persistence-filtered zone flags.
- oMOTION_ANY, out, 1: OR of oZONE_MOTION.
- oREPORT_VALID, out, 1: one-cycle pulse when the outputs update.
- oBUSY, out, 1: high in ACTIVE, DRAIN and REPORT.

Behaviour:
- Reset (iRST_N low, async): all outputs 0, all counters 0, persistence counters 0, state IDLE.
- State IDLE:
  - iFRAME_START latches iTHRESHOLD and iMIN_COUNT.
  - It clears zone counters, column counter and zone index, then goes to ACTIVE.
  - iDVAL and iFRAME_END are ignored.
- State ACTIVE, pipeline stage 1:
  - On each iDVAL, register diff = |iCURR - iPREV|, computed at PIX_WIDTH with no wrap.
  - Register the current zone index alongside it.
- State ACTIVE, pipeline stage 2:
  - If diff > latched threshold (strict), increment that zone's counter.
  - Counters saturate at 2^CNT_WIDTH-1.
- Column and zone tracking:
  - Column counter advances on iDVAL.
  - The zone index increments after every IMG_WIDTH/NUM_ZONES pixels.
  - The column counter wraps to 0 after IMG_WIDTH-1, and the zone index wraps to 0 with it.
- iFRAME_END in ACTIVE goes to DRAIN.
  - A pixel with iDVAL in the same cycle is still counted.
- iFRAME_START in ACTIVE aborts the frame:
  - Counters clear, thresholds re-latch, state stays ACTIVE, no report, persistence untouched.
- State DRAIN: 2 cycles so stage 2 completes, then REPORT.
  - iDVAL is ignored from DRAIN onward.
- State REPORT, 1 cycle:
  - For each zone, hot = count >= latched iMIN_COUNT.
  - A hot zone increments its persistence counter, saturating at PERSIST; a cold zone clears it to 0.
  - Registered outputs: oZONE_MOTION[z] = (persist[z] == PERSIST), computed from the updated value; oZONE_COUNT; oMOTION_ANY.
  - oREPORT_VALID is high the cycle after REPORT, then the state returns to IDLE.
- Latency: iFRAME_END to oREPORT_VALID is 4 cycles.
  - Outputs hold until the next report.
- iFRAME_START during DRAIN or REPORT is ignored.
  - Upstream guarantees at least 4 blanking cycles after iFRAME_END; oBUSY exposes this window.
- Pixel-count rule: fewer than IMG_WIDTH*lines pixels is legal. Counts cover only the pixels received.

Optional Feature:
- Macro: MOTION_PIXEL_MASK_EN.
- Defined: adds outputs oPIX_MOTION (1) and oPIX_VALID (1).
  - oPIX_MOTION is the stage-2 comparison result (diff > threshold).
  - oPIX_VALID is iDVAL delayed 2 cycles, gated to ACTIVE.
  - Both reset to 0. Used for the VGA motion overlay.
- Undefined: these ports and their logic are absent. Zone behaviour is identical either way.

Test Plan:
Bench parameters: IMG_WIDTH=16, NUM_ZONES=4, PERSIST=2, iTHRESHOLD=400, iMIN_COUNT=3.
- Reset mid-ACTIVE: pulse iRST_N low after 5 pixels -> all outputs 0 immediately; next frame reports from clean counters.
- Strict threshold: in zone 1 (columns 4-7), diffs 400, 401, 1023 (iCURR=0, iPREV=1023), 401 -> zone1 count 3; the 400 pixel is not counted; one hot frame -> oZONE_MOTION=0000.
- Persistence: same hot frame as the previous scenario, repeated twice -> second report oZONE_MOTION=0010 and oMOTION_ANY=1; a third frame with zero diffs -> 0000, count 0.
- Wrap and end-of-frame: two 16-pixel lines, column 15 hot on both lines, iFRAME_END with the last iDVAL -> zone3 count 2; oREPORT_VALID exactly 4 cycles after iFRAME_END.
- Abort: iFRAME_START mid-frame after 3 hot pixels in zone 0 -> no oREPORT_VALID; after a clean frame zone0 count 0.
- Saturation (CNT_WIDTH=3, iMIN_COUNT=7): 10 hot pixels in zone 2 -> count 7, zone hot.
